// File: rtl/johnson_pkg.sv
// Shared types and defaults for the Johnson step sequencer slice.
package johnson_pkg;

    // Sequencer control states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default geometry: Johnson stages, step-count width, rate-divider width
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_DIV_W = 8;

    // Step direction encoding as seen on cmd_dir
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_shift.sv
// Bidirectional Johnson register: one step per enabled edge, holds otherwise.
module johnson_shift
    import johnson_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    // Forward feeds the inverted MSB into the LSB; reverse feeds the inverted LSB into the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            if (dir == DIR_FWD) begin
                q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
            end else begin
                q <= {~q[0], q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/johnson_step_sequencer.sv
// Command-driven sequencer that steps a Johnson counter at a divided rate.
// A command (steps, dir, div) is taken through a valid/ready handshake; the
// phase pattern is held between commands so the next one continues from it.
module johnson_step_sequencer
    import johnson_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    state_t             state;
    state_t             state_n;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_cnt_n;
    logic [DIV_W-1:0]   div_lat;
    logic [DIV_W-1:0]   div_lat_n;
    logic               dir_lat;
    logic               dir_lat_n;
    logic [CNT_W-1:0]   steps_left_n;
    logic               busy_n;
    logic               done_n;
    logic               cmd_ready_n;
    logic               step_en;

    johnson_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step_en),
        .dir   (dir_lat),
        .q     (q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Divider, step counter, latched command and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            div_lat    <= '0;
            dir_lat    <= DIR_FWD;
            steps_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            div_cnt    <= div_cnt_n;
            div_lat    <= div_lat_n;
            dir_lat    <= dir_lat_n;
            steps_left <= steps_left_n;
            busy       <= busy_n;
            done       <= done_n;
            cmd_ready  <= cmd_ready_n;
        end
    end

    // Next-state logic; abort takes priority over a pending step, including the final one
    always_comb begin
        state_n      = state;
        div_cnt_n    = div_cnt;
        div_lat_n    = div_lat;
        dir_lat_n    = dir_lat;
        steps_left_n = steps_left;
        busy_n       = busy;
        done_n       = 1'b0;
        cmd_ready_n  = cmd_ready;
        step_en      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    div_lat_n    = cmd_div;
                    dir_lat_n    = cmd_dir;
                    steps_left_n = cmd_steps;
                    div_cnt_n    = '0;
                    if (cmd_steps != '0) begin
                        state_n     = RUN;
                        busy_n      = 1'b1;
                        cmd_ready_n = 1'b0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n     = IDLE;
                    busy_n      = 1'b0;
                    cmd_ready_n = 1'b1;
                    div_cnt_n   = '0;
                end else if (div_cnt == div_lat) begin
                    step_en      = 1'b1;
                    steps_left_n = steps_left - CNT_W'(1);
                    div_cnt_n    = '0;
                    if (steps_left == CNT_W'(1)) begin
                        state_n     = IDLE;
                        busy_n      = 1'b0;
                        cmd_ready_n = 1'b1;
                        done_n      = 1'b1;
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                busy_n      = 1'b0;
                cmd_ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Self-checking bench for johnson_step_sequencer: a per-cycle vector table
// feeding a scoreboard queue, plus a hand-written async-reset sequence.
module tb_johnson_step_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [7:0]  cmd_div;
    logic        abort;
    logic [3:0]  q;
    logic        busy;
    logic        done;
    logic [15:0] steps_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [15:0] steps;
        logic        dir;
        logic [7:0]  div;
        logic        abrt;
        logic [3:0]  exp_q;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_ready;
        logic [15:0] exp_left;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  q;
        logic        busy;
        logic        done;
        logic        ready;
        logic [15:0] left;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    johnson_step_sequencer #(
        .WIDTH (4),
        .CNT_W (16),
        .DIV_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .steps_left (steps_left)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void add_vec(input logic v, input logic [15:0] s, input logic d,
                                    input logic [7:0] dv, input logic a, input logic [3:0] eq,
                                    input logic eb, input logic ed, input logic er,
                                    input logic [15:0] el);
        vec_t t;
        t.valid = v;  t.steps = s;  t.dir = d;  t.div = dv;  t.abrt = a;
        t.exp_q = eq; t.exp_busy = eb; t.exp_done = ed; t.exp_ready = er; t.exp_left = el;
        vecs.push_back(t);
    endfunction

    function automatic void push_exp(input string n, input logic [3:0] eq, input logic eb,
                                     input logic ed, input logic er, input logic [15:0] el);
        exp_t e;
        e.name = n; e.q = eq; e.busy = eb; e.done = ed; e.ready = er; e.left = el;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input vec_t v, input string n);
        cmd_valid = v.valid;
        cmd_steps = v.steps;
        cmd_dir   = v.dir;
        cmd_div   = v.div;
        abort     = v.abrt;
        push_exp(n, v.exp_q, v.exp_busy, v.exp_done, v.exp_ready, v.exp_left);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (q !== e.q) begin
            errors++;
            $display("[TB] FAIL %s q got %b want %b", e.name, q, e.q);
        end
        checks++;
        if (busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s busy got %b want %b", e.name, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
            errors++;
            $display("[TB] FAIL %s done got %b want %b", e.name, done, e.done);
        end
        checks++;
        if (cmd_ready !== e.ready) begin
            errors++;
            $display("[TB] FAIL %s cmd_ready got %b want %b", e.name, cmd_ready, e.ready);
        end
        checks++;
        if (steps_left !== e.left) begin
            errors++;
            $display("[TB] FAIL %s steps_left got %0d want %0d", e.name, steps_left, e.left);
        end
    endtask

    // Main sequence
    initial begin
        logic [3:0] pat [8];
        logic [3:0] prev;
        pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0111; pat[3] = 4'b1111;
        pat[4] = 4'b1110; pat[5] = 4'b1100; pat[6] = 4'b1000; pat[7] = 4'b0000;

        // Basic forward: 3 steps, div 0
        add_vec(1, 3, 0, 0, 0, 4'b0000, 1, 0, 0, 3);
        add_vec(0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, 2);
        add_vec(0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 4'b0111, 0, 1, 1, 0);
        // Back-to-back reverse accepted during the done cycle
        add_vec(1, 2, 1, 0, 0, 4'b0111, 1, 0, 0, 2);
        add_vec(0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 4'b0001, 0, 1, 1, 0);
        // Zero-step command accepted in the done cycle keeps done high
        add_vec(1, 0, 0, 0, 0, 4'b0001, 0, 1, 1, 0);
        add_vec(0, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 0);
        // One reverse step back to 0000
        add_vec(1, 1, 1, 0, 0, 4'b0001, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
        // Full forward wrap with div 2; a stray command mid-run is ignored
        add_vec(1, 8, 0, 2, 0, 4'b0000, 1, 0, 0, 8);
        prev = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            add_vec((k == 3), 16'd3, 1, 0, 0, prev, 1, 0, 0, 16'(8 - k));
            add_vec(0, 0, 0, 0, 0, prev, 1, 0, 0, 16'(8 - k));
            add_vec(0, 0, 0, 0, 0, pat[k], (k != 7), (k == 7), (k == 7), 16'(7 - k));
            prev = pat[k];
        end
        add_vec(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        // Abort after two steps
        add_vec(1, 5, 0, 0, 0, 4'b0000, 1, 0, 0, 5);
        add_vec(1, 9, 1, 0, 0, 4'b0001, 1, 0, 0, 4);
        add_vec(0, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 3);
        add_vec(0, 0, 0, 0, 1, 4'b0011, 0, 0, 1, 3);
        add_vec(0, 0, 0, 0, 1, 4'b0011, 0, 0, 1, 3);
        // Abort coincident with the final step
        add_vec(1, 2, 1, 0, 0, 4'b0011, 1, 0, 0, 2);
        add_vec(0, 0, 0, 0, 0, 4'b0001, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0, 1, 4'b0001, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 1);

        cmd_valid = 0; cmd_steps = '0; cmd_dir = 0; cmd_div = '0; abort = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 4'b0000, 0, 0, 1, 0);
        checkOutput();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            checkOutput();
        end

        // Async reset mid-period of a long run
        @(negedge clk);
        cmd_valid = 1; cmd_steps = 16'd100; cmd_dir = 0; cmd_div = 8'd4; abort = 0;
        push_exp("long_accept", 4'b0001, 1, 0, 0, 100);
        @(posedge clk);
        #1;
        checkOutput();
        cmd_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        push_exp("long_first_step", 4'b0011, 1, 0, 0, 99);
        checkOutput();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        push_exp("async_reset", 4'b0000, 0, 0, 1, 0);
        checkOutput();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        push_exp("after_reset", 4'b0000, 0, 0, 1, 0);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
